// File: rtl/cycle_counter.sv
// Iteration counter for the mult-div unit: one start-to-done session at a time,
// counting up to or down from a captured limit, with an optional free-running wrap mode.
module cycle_counter #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             abort,
    input  logic             ena,
    input  logic [WIDTH-1:0] limit,
    input  logic             mode_down,
    input  logic             wrap,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state;
    logic [WIDTH-1:0] lim_q;
    logic             dir_q;
    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] init;

    // The step never crosses term, so the modulo wrap of +/-1 is never exercised in use.
    function automatic logic [WIDTH-1:0] next_count(input logic [WIDTH-1:0] cur,
                                                    input logic             down);
        next_count = down ? (cur - ONE) : (cur + ONE);
    endfunction

    assign term = dir_q ? '0 : lim_q;
    assign init = dir_q ? lim_q : '0;

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign tc   = busy && (out == term);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
            out   <= '0;
            lim_q <= '0;
            dir_q <= 1'b0;
        end else if (abort) begin
            state <= IDLE;
        end else if (start) begin
            // init must come from the live inputs: lim_q/dir_q update on this same edge.
            lim_q <= limit;
            dir_q <= mode_down;
            out   <= mode_down ? limit : '0;
            state <= RUN;
        end else begin
            case (state)
                RUN: begin
                    if (ena) begin
                        if (out == term) begin
                            if (wrap) begin
                                out <= init;
                            end else begin
                                state <= DONE;
                            end
                        end else begin
                            out <= next_count(out, dir_q);
                        end
                    end
                end
                DONE:    state <= IDLE;
                IDLE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cycle_counter.sv
// Directed bench for cycle_counter: reset, up/down/stall sessions, wrap, limit=0,
// mid-session limit changes and start/abort priority.
module tb_cycle_counter;
    localparam int WIDTH = 6;

    logic             clk;
    logic             clr;
    logic             start;
    logic             abort;
    logic             ena;
    logic [WIDTH-1:0] limit;
    logic             mode_down;
    logic             wrap;
    logic [WIDTH-1:0] out;
    logic             busy;
    logic             tc;
    logic             done;

    int n_cmp;
    int n_err;

    cycle_counter #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .abort    (abort),
        .ena      (ena),
        .limit    (limit),
        .mode_down(mode_down),
        .wrap     (wrap),
        .out      (out),
        .busy     (busy),
        .tc       (tc),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int e_out, input bit e_busy,
                           input bit e_tc, input bit e_done);
        chk({tag, ".out"},  32'(out),  32'(e_out));
        chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
        chk({tag, ".tc"},   32'(tc),   32'(e_tc));
        chk({tag, ".done"}, 32'(done), 32'(e_done));
    endtask

    initial begin
        int exp_dn [8];
        bit ena_dn [8];
        n_cmp = 0;
        n_err = 0;
        clr = 1'b1; start = 1'b0; abort = 1'b0; ena = 1'b0;
        limit = '0; mode_down = 1'b0; wrap = 1'b0;
        #12;
        chk_all("reset", 0, 0, 0, 0);
        clr = 1'b0;
        step();
        chk_all("idle_after_reset", 0, 0, 0, 0);

        // Up one-shot, limit 31
        limit = 6'd31; mode_down = 1'b0; ena = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i <= 31; i++) begin
            chk_all($sformatf("up31_%0d", i), i, 1, (i == 31), 0);
            if (i < 31) step();
        end
        step();
        chk_all("up31_done", 31, 0, 0, 1);
        step();
        chk_all("up31_idle", 31, 0, 0, 0);
        step();
        chk_all("up31_hold", 31, 0, 0, 0);

        // Asynchronous reset mid-session at out=12
        limit = 6'd20; start = 1'b1;
        step();
        start = 1'b0;
        repeat (12) step();
        chk("pre_clr.out", 32'(out), 32'd12);
        clr = 1'b1;
        #2;
        chk_all("async_clr", 0, 0, 0, 0);
        #1;
        clr = 1'b0;
        step();
        step();
        chk_all("post_clr_idle", 0, 0, 0, 0);

        // Down with two stall cycles at out=3
        exp_dn = '{5, 4, 3, 3, 3, 2, 1, 0};
        ena_dn = '{1, 1, 0, 0, 1, 1, 1, 1};
        limit = 6'd5; mode_down = 1'b1; ena = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        mode_down = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk_all($sformatf("down_%0d", i), exp_dn[i], 1, (exp_dn[i] == 0), 0);
            ena = ena_dn[i];
            step();
        end
        chk_all("down_done", 0, 0, 0, 1);
        step();
        chk_all("down_idle", 0, 0, 0, 0);

        // Wrap mode, limit 3, then abort at out=2
        limit = 6'd3; wrap = 1'b1; ena = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            chk_all($sformatf("wrap_%0d", i), i % 4, 1, ((i % 4) == 3), 0);
            if (i < 10) step();
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_all("wrap_abort", 2, 0, 0, 0);
        wrap = 1'b0;
        step();
        chk_all("wrap_abort_hold", 2, 0, 0, 0);

        // limit = 0
        limit = 6'd0; start = 1'b1;
        step();
        start = 1'b0;
        chk_all("lim0_run", 0, 1, 1, 0);
        step();
        chk_all("lim0_done", 0, 0, 0, 1);
        step();
        chk_all("lim0_idle", 0, 0, 0, 0);

        // limit raised to 40 mid-session has no effect
        limit = 6'd10; start = 1'b1;
        step();
        start = 1'b0;
        limit = 6'd40;
        mode_down = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            chk_all($sformatf("lim40_%0d", i), i, 1, (i == 10), 0);
            if (i < 10) step();
        end
        step();
        chk_all("lim40_done", 10, 0, 0, 1);
        mode_down = 1'b0;
        step();

        // start during RUN at out=7 reloads with new limit 9
        limit = 6'd20; start = 1'b1;
        step();
        start = 1'b0;
        repeat (7) step();
        chk("restart_pre.out", 32'(out), 32'd7);
        limit = 6'd9; start = 1'b1;
        step();
        start = 1'b0;
        chk_all("restart_0", 0, 1, 0, 0);
        repeat (9) step();
        chk_all("restart_9", 9, 1, 1, 0);
        step();
        chk_all("restart_done", 9, 0, 0, 1);
        step();

        // start together with abort: abort wins
        limit = 6'd20; start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        limit = 6'd30; start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        chk_all("start_abort", 3, 0, 0, 0);
        step();
        chk_all("start_abort_hold", 3, 0, 0, 0);

        // start on the DONE->IDLE edge begins a new session
        limit = 6'd1; start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk_all("b2b_tc", 1, 1, 1, 0);
        step();
        chk_all("b2b_done", 1, 0, 0, 1);
        limit = 6'd2; start = 1'b1;
        step();
        start = 1'b0;
        chk_all("b2b_restart", 0, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
